// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory request/response channel plus the
// decode-side instruction handshake and redirect inputs.
interface fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_pc, inst_data,
      input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_pc, inst_data,
      output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue with credit-limited memory requests and redirect flush.
// Optional macro FETCH_STALL_CNT_EN adds the fetch_stall_cnt output.
module fetch_queue #(
   parameter int          DEPTH     = 4,
   parameter int          MAX_OUTST = 2,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           reset,
   fetch_queue_if.master  bus
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0]    fetch_stall_cnt
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTST);

   logic [31:0]   fpc_q, fpc_d;
   logic [31:0]   rpc_q, rpc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   data_mem_q [DEPTH];

   logic [CW:0]   credit_s;
   logic          req_s, gnt_s, rsp_s, drop_s, push_s, pop_s, valid_s;
   logic [31:0]   target_s;

   // Request/response qualification; rvalid with nothing outstanding is ignored.
   always_comb begin
      credit_s = {1'b0, count_q} + {1'b0, outst_q};
      req_s    = !reset && !bus.redirect && (outst_q < MAX_C) && (credit_s < {1'b0, DEPTH_C});
      gnt_s    = req_s && bus.imem_gnt;
      rsp_s    = bus.imem_rvalid && (outst_q != {CW{1'b0}});
      drop_s   = rsp_s && (discard_q != {CW{1'b0}});
      push_s   = rsp_s && (discard_q == {CW{1'b0}}) && !bus.redirect;
      valid_s  = (count_q != {CW{1'b0}});
      pop_s    = valid_s && bus.inst_ready && !bus.redirect;
      target_s = bus.redirect_pc & 32'hFFFF_FFFC;
   end

   // Next-state for fetch/response PCs, credit counters and queue pointers.
   always_comb begin
      fpc_d     = fpc_q;
      rpc_d     = rpc_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      outst_d   = outst_q;
      discard_d = discard_q;

      if (gnt_s && !rsp_s) begin
         outst_d = outst_q + CW'(1);
      end else if (!gnt_s && rsp_s) begin
         outst_d = outst_q - CW'(1);
      end else begin
         outst_d = outst_q;
      end

      if (bus.redirect) begin
         // Everything still in flight after this cycle belongs to the old path.
         fpc_d     = target_s;
         rpc_d     = target_s;
         rd_ptr_d  = {PW{1'b0}};
         wr_ptr_d  = {PW{1'b0}};
         count_d   = {CW{1'b0}};
         discard_d = outst_d;
      end else begin
         if (gnt_s) begin
            fpc_d = fpc_q + 32'd4;
         end else begin
            fpc_d = fpc_q;
         end
         if (drop_s) begin
            discard_d = discard_q - CW'(1);
         end else begin
            discard_d = discard_q;
         end
         if (push_s) begin
            rpc_d    = rpc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            rpc_d    = rpc_q;
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
         end else if (!push_s && pop_s) begin
            count_d = count_q - CW'(1);
         end else begin
            count_d = count_q;
         end
      end
   end

   // Control state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fpc_q     <= RESET_PC;
         rpc_q     <= RESET_PC;
         rd_ptr_q  <= {PW{1'b0}};
         wr_ptr_q  <= {PW{1'b0}};
         count_q   <= {CW{1'b0}};
         outst_q   <= {CW{1'b0}};
         discard_q <= {CW{1'b0}};
      end else begin
         fpc_q     <= fpc_d;
         rpc_q     <= rpc_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
      end
   end

   // Queue storage, written at the tail by accepted responses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= 32'h0;
            data_mem_q[i] <= 32'h0;
         end
      end else if (push_s) begin
         pc_mem_q[wr_ptr_q]   <= rpc_q;
         data_mem_q[wr_ptr_q] <= bus.imem_rdata;
      end
   end

   assign bus.imem_req   = req_s;
   assign bus.imem_addr  = fpc_q;
   assign bus.inst_valid = valid_s;
   assign bus.inst_pc    = valid_s ? pc_mem_q[rd_ptr_q]   : 32'h0;
   assign bus.inst_data  = valid_s ? data_mem_q[rd_ptr_q] : 32'h0;

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where decode holds off a valid head.
   always_comb begin
      if (valid_s && !bus.inst_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= 32'h0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule
